// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and defaults for the instruction fetch queue.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_ACK = 2'd1, DRAIN = 2'd2} state_e;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int STALL_W = 16;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: registered FIFO with separate occupancy count; flush beats push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W = DEF_ADDR_W + DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    do_push = push && !flush && (cnt_q < CW'(DEPTH));
    do_pop = pop && !flush && (cnt_q != '0);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d = flush ? '0 : wr_q + PW'(do_push);
    rd_d = flush ? '0 : rd_q + PW'(do_pop);
    cnt_d = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign count = cnt_q;
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetches each accepted PC over req/ack and queues {pc, instr} for decode.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [ADDR_W-1:0]        pc_in,
  input  logic                     pc_valid,
  output logic                     pc_ready,
  input  logic                     flush,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_ack,
  input  logic [DATA_W-1:0]        imem_rdata,
  output logic                     if_valid,
  output logic [ADDR_W-1:0]        if_pc,
  output logic [DATA_W-1:0]        if_instr,
  input  logic                     id_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [STALL_W-1:0]       stall_cycles
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_e state_q, state_d;
  logic req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic push;
  assign pc_ready = (state_q == IDLE) && !flush && (fifo_count < CW'(DEPTH));
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    push = 1'b0;
    case (state_q)
      IDLE: if (pc_valid && pc_ready) begin
        addr_d = pc_in;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: if (imem_ack) begin
        push = !flush;
        state_d = IDLE;
      end else if (flush) state_d = DRAIN;
      DRAIN: if (imem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req_d = state_d != IDLE;
    stall_d = (state_q != IDLE && stall_q != STALL_MAX) ? stall_q + STALL_W'(1) : stall_q;
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      req_q <= 1'b0;
      addr_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      addr_q <= addr_d;
      stall_q <= stall_d;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH), .W(ADDR_W + DATA_W)) u_fifo (
    .clk(clk),
    .clr(clr),
    .push(push),
    .pop(id_ready && if_valid),
    .flush(flush),
    .din({addr_q, imem_rdata}),
    .dout({if_pc, if_instr}),
    .count(fifo_count)
  );
  assign if_valid = fifo_count != '0;
  assign imem_req = req_q;
  assign imem_addr = addr_q;
  assign stall_cycles = stall_q;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed stimulus with a scoreboard queue checked by an output monitor.
module tb_instr_fetch_queue;
  logic clk = 0, clr = 1;
  logic [31:0] pc_in = 0;
  logic pc_valid = 0, pc_ready, flush = 0;
  logic imem_req, imem_ack = 0;
  logic [31:0] imem_addr, imem_rdata = 0;
  logic if_valid, id_ready = 0;
  logic [31:0] if_pc, if_instr;
  logic [2:0] fifo_count;
  logic [15:0] stall_cycles;
  logic [63:0] exp_q[$];
  int pass_cnt = 0, total_cnt = 0;
  int mem_lat = 0, wcnt = 0;
  bit mem_hold = 0;

  instr_fetch_queue dut (
    .clk(clk), .clr(clr), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .id_ready(id_ready), .fifo_count(fifo_count), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return (pc == 32'h40) ? 32'h8210_0005 : (32'hA000_0000 | pc);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // memory: acks after mem_lat extra request cycles unless held
  always @(posedge clk) begin
    #1;
    if (clr || !imem_req) begin
      imem_ack = 0;
      wcnt = 0;
    end else begin
      imem_ack = !mem_hold && wcnt >= mem_lat;
      imem_rdata = instr_of(imem_addr);
      if (!mem_hold) wcnt++;
    end
  end

  always @(negedge clk) begin
    if (!clr) begin
      if (flush) exp_q.delete();
      else if (if_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_out: got %h_%h expected none", if_pc, if_instr);
        end else chk("out", {if_pc, if_instr}, exp_q.pop_front());
      end
    end
  end

  task automatic rst();
    clr = 1; pc_valid = 0; flush = 0; id_ready = 0; mem_lat = 0; mem_hold = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 clr = 0;
  endtask

  task automatic send(input logic [31:0] pc, input bit expect_out);
    int n = 0;
    pc_in = pc;
    pc_valid = 1;
    @(negedge clk);
    while (!pc_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!pc_ready) chk("send_timeout", 0, 1);
    else if (expect_out) exp_q.push_back({pc, instr_of(pc)});
    @(posedge clk);
    #1 pc_valid = 0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_remaining", 64'(exp_q.size()), 0);
  endtask

  initial begin
    rst();
    @(negedge clk);
    chk("rst_pc_ready", pc_ready, 1);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_head", {if_pc, if_instr}, 0);
    // single fetch
    @(posedge clk); #1;
    send(32'h40, 1);
    @(negedge clk);
    chk("single_req_c2", imem_req, 1);
    chk("single_valid_c2", if_valid, 0);
    @(negedge clk);
    chk("single_req_c3", imem_req, 0);
    chk("single_valid_c3", if_valid, 1);
    chk("single_pc", if_pc, 32'h40);
    chk("single_instr", if_instr, 32'h8210_0005);
    @(posedge clk); #1 id_ready = 1;
    wait_empty();
    // fill to full
    rst();
    for (int i = 0; i < 4; i++) send(32'(4 * i), 1);
    @(negedge clk);
    @(negedge clk);
    chk("full_count", fifo_count, 4);
    chk("full_pc_ready", pc_ready, 0);
    @(posedge clk); #1 id_ready = 1;
    @(negedge clk);
    chk("full_pc_ready_pre_pop", pc_ready, 0);
    @(negedge clk);
    chk("full_pc_ready_post_pop", pc_ready, 1);
    wait_empty();
    // flush with ack outstanding
    rst();
    mem_lat = 2;
    send(32'h100, 0);
    flush = 1;
    @(negedge clk);
    chk("flush_pc_ready", pc_ready, 0);
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    chk("drain_req", imem_req, 1);
    chk("drain_addr", imem_addr, 32'h100);
    @(negedge clk);
    chk("drain_req_ack", imem_req, 1);
    chk("drain_ack_seen", imem_ack, 1);
    @(negedge clk);
    chk("drain_count", fifo_count, 0);
    chk("drain_pc_ready", pc_ready, 1);
    chk("drain_stall", stall_cycles, 3);
    chk("drain_valid", if_valid, 0);
    // flush coinciding with ack and pop
    rst();
    send(32'h200, 1);
    send(32'h204, 1);
    send(32'h208, 0);
    chk("coinc_count_before", fifo_count, 2);
    flush = 1;
    id_ready = 1;
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    chk("coinc_count", fifo_count, 0);
    chk("coinc_valid", if_valid, 0);
    repeat (5) @(negedge clk);
    // wrap-around
    rst();
    id_ready = 1;
    for (int i = 0; i < 10; i++) send(32'h1000 + 32'(4 * i), 1);
    wait_empty();
    // stall counter saturation
    rst();
    id_ready = 1;
    mem_hold = 1;
    send(32'h3000, 1);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("sat_stall", stall_cycles, 16'hFFFF);
    chk("sat_req", imem_req, 1);
    @(posedge clk); #1 mem_hold = 0;
    repeat (3) @(negedge clk);
    chk("sat_stall_after", stall_cycles, 16'hFFFF);
    wait_empty();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
